// File: rtl/r4_fft_out_reorder.sv
// Reorders radix-4 FFT results from base-4 digit-reversed order into natural bin order.
// Ping-pong banks; first word out one clock after a bank fills; in_ready drops only when both banks hold frames.
module r4_fft_out_reorder #(
    parameter int LOG4N = 2,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [DW-1:0]        in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [2*LOG4N-1:0]   out_index,
    output logic                 out_last
);

    localparam int AW = 2 * LOG4N;
    localparam int N  = 1 << AW;
    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);

    function automatic logic [AW-1:0] drev(input logic [AW-1:0] j);
        logic [AW-1:0] r;
        r = '0;
        for (int k = 0; k < LOG4N; k++) begin
            r[2*k +: 2] = j[2*(LOG4N-1-k) +: 2];
        end
        return r;
    endfunction

    logic [DW-1:0] mem_q [0:2*N-1];

    logic [1:0]    full_q, full_d;
    logic          wb_q, wb_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic          rb_q, rb_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic          ov_q, ov_d;
    logic [DW-1:0] od_q, od_d;
    logic [AW-1:0] oi_q, oi_d;
    logic          ol_q, ol_d;

    logic wr_fire;
    logic rd_load;

    assign in_ready  = !full_q[wb_q];
    assign wr_fire   = in_valid && in_ready;
    assign rd_load   = (!ov_q || out_ready) && full_q[rb_q];

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_index = oi_q;
    assign out_last  = ol_q;

    always_comb begin
        full_d = full_q;
        wb_d   = wb_q;
        wcnt_d = wcnt_q;
        rb_d   = rb_q;
        rcnt_d = rcnt_q;
        ov_d   = ov_q;
        od_d   = od_q;
        oi_d   = oi_q;
        ol_d   = ol_q;

        if (wr_fire) begin
            wcnt_d = wcnt_q + CNT_ONE;
            if (wcnt_q == CNT_LAST) begin
                full_d[wb_q] = 1'b1;
                wb_d         = !wb_q;
                wcnt_d       = '0;
            end
        end

        // Fill and free always target different banks, so both updates to full_d compose.
        if (rd_load) begin
            od_d   = mem_q[{rb_q, rcnt_q}];
            oi_d   = rcnt_q;
            ol_d   = (rcnt_q == CNT_LAST);
            ov_d   = 1'b1;
            rcnt_d = rcnt_q + CNT_ONE;
            if (rcnt_q == CNT_LAST) begin
                full_d[rb_q] = 1'b0;
                rb_d         = !rb_q;
                rcnt_d       = '0;
            end
        end else if (out_ready) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 2'b00;
            wb_q   <= 1'b0;
            wcnt_q <= '0;
            rb_q   <= 1'b0;
            rcnt_q <= '0;
            ov_q   <= 1'b0;
            od_q   <= '0;
            oi_q   <= '0;
            ol_q   <= 1'b0;
        end else begin
            full_q <= full_d;
            wb_q   <= wb_d;
            wcnt_q <= wcnt_d;
            rb_q   <= rb_d;
            rcnt_q <= rcnt_d;
            ov_q   <= ov_d;
            od_q   <= od_d;
            oi_q   <= oi_d;
            ol_q   <= ol_d;
        end
    end

    // Storage needs no reset: a bank is only read after it has been completely written.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[{wb_q, drev(wcnt_q)}] <= in_data;
        end
    end

endmodule
